// File: rtl/dest_ip_tbl_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dest_ip_tbl_ctrl_pkg : shared types and constants for the table ctrl     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dest_ip_tbl_ctrl_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_NUM_ENTRIES    = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    localparam logic REQ_REG = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_CLR_WAIT = 2'd2
    } state_e;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_CPU) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dest_ip_tbl_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dest_ip_tbl_ctrl_if : requester, clear and table-port signal bundle      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface dest_ip_tbl_ctrl_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5
) ();
    logic [1:0]                      rq_valid;
    logic [1:0]                      rq_wr;
    logic [2*TBL_ADDR_WIDTH-1:0]     rq_addr;
    logic [2*C_S_AXI_DATA_WIDTH-1:0] rq_wdata;
    logic [1:0]                      rq_accept;
    logic [1:0]                      rsp_valid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata;
    logic                            rsp_timeout;
    logic                            clr_start;
    logic                            clr_busy;
    logic                            clr_done;
    logic                            tbl_rd_req;
    logic                            tbl_wr_req;
    logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr;
    logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data;
    logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data;
    logic                            tbl_rd_ack;
    logic                            tbl_wr_ack;

    modport master (
        input  rq_valid, rq_wr, rq_addr, rq_wdata, clr_start,
        input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
        output rq_accept, rsp_valid, rsp_rdata, rsp_timeout, clr_busy, clr_done,
        output tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data
    );

    modport slave (
        output rq_valid, rq_wr, rq_addr, rq_wdata, clr_start,
        output tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
        input  rq_accept, rsp_valid, rsp_rdata, rsp_timeout, clr_busy, clr_done,
        input  tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/dest_ip_tbl_ctrl_rr_arbiter_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter_2 : two-input round-robin grant, pointer holds priority       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter_2 (
    input  wire logic [1:0] req_i,
    input  wire logic       ptr_i,
    output logic            gnt_valid_o,
    output logic            gnt_idx_o
);
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = req_i[ptr_i] ? ptr_i : ~ptr_i;
    end
endmodule
`default_nettype wire

// File: rtl/dest_ip_tbl_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dest_ip_tbl_ctrl : arbitrated single-port access to the dest-IP table,   |
// | with ack timeout and a zeroing clear sequencer.  Rev 1.0                 |
// +--------------------------------------------------------------------------+
module dest_ip_tbl_ctrl
    import dest_ip_tbl_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TBL_ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int NUM_ENTRIES        = DEF_NUM_ENTRIES,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  wire logic        AXI_ACLK,
    input  wire logic        AXI_RESET,
    dest_ip_tbl_ctrl_if.master bus
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = TBL_ADDR_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            clr_pend_q, clr_pend_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            gnt_q, gnt_d;
    logic            wr_q, wr_d;
    logic [1:0]      rq_accept_q, rq_accept_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic            clr_busy_q, clr_busy_d;
    logic            clr_done_q, clr_done_d;
    logic            rd_req_q, rd_req_d;
    logic            wr_req_q, wr_req_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic            w_gnt_valid;
    logic            w_gnt_idx;
    logic [AW-1:0]   w_req_addr;
    logic [DW-1:0]   w_req_wdata;
    logic            w_req_wr;
    logic            w_ack_match;
    logic            w_timer_exp;

    rr_arbiter_2 u_arb (
        .req_i       (bus.rq_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (w_gnt_valid),
        .gnt_idx_o   (w_gnt_idx)
    );

    assign w_req_addr  = w_gnt_idx ? bus.rq_addr[2*AW-1:AW]  : bus.rq_addr[AW-1:0];
    assign w_req_wdata = w_gnt_idx ? bus.rq_wdata[2*DW-1:DW] : bus.rq_wdata[DW-1:0];
    assign w_req_wr    = bus.rq_wr[w_gnt_idx];
    // Only the ack matching the issued direction completes a transaction.
    assign w_ack_match = wr_q ? bus.tbl_wr_ack : bus.tbl_rd_ack;
    assign w_timer_exp = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        clr_pend_d    = clr_pend_q;
        clr_idx_d     = clr_idx_q;
        timer_d       = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
        gnt_d         = gnt_q;
        wr_d          = wr_q;
        rq_accept_d   = 2'b00;
        rsp_valid_d   = 2'b00;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = 1'b0;
        clr_done_d    = 1'b0;
        rd_req_d      = 1'b0;
        wr_req_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        if (bus.clr_start && !clr_busy_q) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q) begin
                    wr_req_d  = 1'b1;
                    wr_addr_d = clr_idx_q;
                    wr_data_d = '0;
                    timer_d   = '0;
                    state_d   = ST_CLR_WAIT;
                end else if (w_gnt_valid) begin
                    gnt_d       = w_gnt_idx;
                    wr_d        = w_req_wr;
                    rq_accept_d = req_onehot(w_gnt_idx);
                    if (w_req_wr) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = w_req_addr;
                        wr_data_d = w_req_wdata;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = w_req_addr;
                    end
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ack_match || w_timer_exp) begin
                    rsp_valid_d   = req_onehot(gnt_q);
                    rsp_timeout_d = !w_ack_match;
                    rsp_rdata_d   = (w_ack_match && !wr_q) ? bus.tbl_rd_data : '0;
                    rr_ptr_d      = ~gnt_q;
                    state_d       = ST_IDLE;
                end
            end
            ST_CLR_WAIT: begin
                if (bus.tbl_wr_ack) begin
                    if (clr_idx_q == AW'(NUM_ENTRIES - 1)) begin
                        clr_done_d = 1'b1;
                        clr_pend_d = 1'b0;
                        clr_idx_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                        wr_req_d  = 1'b1;
                        wr_addr_d = clr_idx_q + 1'b1;
                        wr_data_d = '0;
                        timer_d   = '0;
                    end
                end else if (w_timer_exp) begin
                    clr_done_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                    clr_pend_d    = 1'b0;
                    clr_idx_d     = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        clr_busy_d = clr_pend_d || (state_d == ST_CLR_WAIT);
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= 1'b0;
            clr_pend_q    <= 1'b0;
            clr_idx_q     <= '0;
            timer_q       <= '0;
            gnt_q         <= 1'b0;
            wr_q          <= 1'b0;
            rq_accept_q   <= 2'b00;
            rsp_valid_q   <= 2'b00;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            clr_busy_q    <= 1'b0;
            clr_done_q    <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            clr_pend_q    <= clr_pend_d;
            clr_idx_q     <= clr_idx_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            wr_q          <= wr_d;
            rq_accept_q   <= rq_accept_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            clr_busy_q    <= clr_busy_d;
            clr_done_q    <= clr_done_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.rq_accept   = rq_accept_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.clr_busy    = clr_busy_q;
    assign bus.clr_done    = clr_done_q;
    assign bus.tbl_rd_req  = rd_req_q;
    assign bus.tbl_wr_req  = wr_req_q;
    assign bus.tbl_rd_addr = rd_addr_q;
    assign bus.tbl_wr_addr = wr_addr_q;
    assign bus.tbl_wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dest_ip_tbl_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dest_ip_tbl_ctrl : directed self-checking bench with a table model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dest_ip_tbl_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dest_ip_tbl_ctrl_if #(.C_S_AXI_DATA_WIDTH(32), .TBL_ADDR_WIDTH(5)) bus ();

    dest_ip_tbl_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .TBL_ADDR_WIDTH     (5),
        .NUM_ENTRIES        (32),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .AXI_ACLK  (clk),
        .AXI_RESET (rst),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Table model: acks one cycle after sampling a request when enabled.
    logic [31:0] mem [32];
    logic        ack_en = 1'b1;
    logic        m_rd_ack = 1'b0, m_wr_ack = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic        inj_rd_ack = 1'b0;
    logic [31:0] inj_data = '0;

    initial for (int i = 0; i < 32; i++) mem[i] = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m_rd_ack <= ack_en & bus.tbl_rd_req;
        m_wr_ack <= ack_en & bus.tbl_wr_req;
        if (bus.tbl_rd_req) m_rd_data <= mem[bus.tbl_rd_addr];
        if (bus.tbl_wr_req) mem[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end

    assign bus.tbl_rd_ack  = m_rd_ack | inj_rd_ack;
    assign bus.tbl_wr_ack  = m_wr_ack;
    assign bus.tbl_rd_data = inj_rd_ack ? inj_data : m_rd_data;

    // Clear-phase monitor
    logic mon_en = 1'b0;
    int clr_wr_cnt = 0, clr_addr_err = 0, clr_data_err = 0;
    int clr_done_cnt = 0, clr_to_cnt = 0, acc_busy = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.tbl_wr_req && bus.clr_busy) begin
                if (bus.tbl_wr_addr != clr_wr_cnt[4:0]) clr_addr_err++;
                if (bus.tbl_wr_data != 32'd0) clr_data_err++;
                clr_wr_cnt++;
            end
            if (bus.clr_done) begin
                clr_done_cnt++;
                if (bus.rsp_timeout) clr_to_cnt++;
            end
            if (bus.rq_accept != 2'b00 && bus.clr_busy) acc_busy++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input int r, input logic wr, input logic [4:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic to, output int lat);
        bit got;
        got = 0; lat = 0; rd = '0; to = 1'b0;
        if (r == 0) begin
            bus.rq_wr[0] = wr; bus.rq_addr[4:0] = a; bus.rq_wdata[31:0] = d; bus.rq_valid[0] = 1'b1;
        end else begin
            bus.rq_wr[1] = wr; bus.rq_addr[9:5] = a; bus.rq_wdata[63:32] = d; bus.rq_valid[1] = 1'b1;
        end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.rq_accept[r]) got = 1;
        end
        bus.rq_valid[r] = 1'b0;
        chk("req_accept_seen", 64'(got), 64'd1);
        got = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[r]) begin
                got = 1; lat = k; rd = bus.rsp_rdata; to = bus.rsp_timeout;
            end
        end
        chk("req_rsp_seen", 64'(got), 64'd1);
    endtask

    logic [31:0] rd;
    logic        to;
    int          lat;
    int          ord [4];
    int          acc_cyc [4];
    int          n, rem0, rem1, late;
    bit          got1;

    initial begin
        bus.rq_valid = '0; bus.rq_wr = '0; bus.rq_addr = '0; bus.rq_wdata = '0;
        bus.clr_start = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_accept", 64'(bus.rq_accept), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_tbl_req", 64'({bus.tbl_rd_req, bus.tbl_wr_req}), 64'd0);
        chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
        chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst = 1'b0;

        // 1. Write req0 addr 5
        bus.rq_wr[0] = 1'b1; bus.rq_addr[4:0] = 5'd5; bus.rq_wdata[31:0] = 32'h0A000001;
        bus.rq_valid[0] = 1'b1;
        @(negedge clk);
        chk("wr_accept", 64'(bus.rq_accept), 64'd1);
        chk("wr_req", 64'({bus.tbl_rd_req, bus.tbl_wr_req}), 64'd1);
        chk("wr_addr", 64'(bus.tbl_wr_addr), 64'd5);
        chk("wr_data", 64'(bus.tbl_wr_data), 64'h0A000001);
        bus.rq_valid[0] = 1'b0;
        @(negedge clk);
        chk("wr_rsp_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("wr_rsp_to", 64'(bus.rsp_timeout), 64'd0);

        // 2. Read req1 addr 5
        bus.rq_wr[1] = 1'b0; bus.rq_addr[9:5] = 5'd5; bus.rq_valid[1] = 1'b1;
        @(negedge clk);
        chk("rd_accept", 64'(bus.rq_accept), 64'd2);
        chk("rd_req", 64'({bus.tbl_rd_req, bus.tbl_wr_req}), 64'd2);
        chk("rd_addr", 64'(bus.tbl_rd_addr), 64'd5);
        bus.rq_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'd2);
        chk("rd_rdata", 64'(bus.rsp_rdata), 64'h0A000001);

        // 3. Contention, two requests each
        bus.rq_wr = 2'b00;
        rem0 = 2; rem1 = 2; n = 0;
        bus.rq_valid = 2'b11;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (bus.rq_accept[0]) begin ord[n] = 0; acc_cyc[n] = cyc; n++; rem0--; end
            if (bus.rq_accept[1] && n < 4) begin ord[n] = 1; acc_cyc[n] = cyc; n++; rem1--; end
            bus.rq_valid = {rem1 != 0, rem0 != 0};
        end
        bus.rq_valid = 2'b00;
        chk("arb_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) chk("arb_order", 64'(ord[i]), 64'(i % 2));
        for (int i = 1; i < 4; i++) chk("arb_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        repeat (3) @(negedge clk);

        // 4. Timeout, then a normal request
        ack_en = 1'b0;
        run_req(0, 1'b0, 5'd7, 32'd0, rd, to, lat);
        chk("to_latency", 64'(lat), 64'd16);
        chk("to_flag", 64'(to), 64'd1);
        chk("to_rdata", 64'(rd), 64'd0);
        ack_en = 1'b1;
        run_req(1, 1'b1, 5'd9, 32'h55, rd, to, lat);
        chk("post_to_flag", 64'(to), 64'd0);
        chk("post_to_lat", 64'(lat), 64'd2);

        // 5. Clear during a req0 read; req1 waits for the clear
        bus.rq_wr[0] = 1'b0; bus.rq_addr[4:0] = 5'd9; bus.rq_valid[0] = 1'b1;
        @(negedge clk);
        chk("clr_rd_accept", 64'(bus.rq_accept), 64'd1);
        mon_en = 1'b1;
        bus.rq_valid[0] = 1'b0;
        bus.clr_start = 1'b1;
        bus.rq_wr[1] = 1'b1; bus.rq_addr[9:5] = 5'd4; bus.rq_wdata[63:32] = 32'h77;
        bus.rq_valid[1] = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        chk("clr_busy_set", 64'(bus.clr_busy), 64'd1);
        @(negedge clk);
        chk("clr_rd_rsp", 64'(bus.rsp_valid), 64'd1);
        chk("clr_rd_data", 64'(bus.rsp_rdata), 64'h55);
        got1 = 0;
        for (int k = 0; k < 200 && !got1; k++) begin
            @(negedge clk);
            if (bus.rq_accept[1]) got1 = 1;
        end
        bus.rq_valid[1] = 1'b0;
        chk("clr_req1_accept", 64'(got1), 64'd1);
        got1 = 0;
        for (int k = 0; k < 20 && !got1; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[1]) begin got1 = 1; to = bus.rsp_timeout; end
        end
        chk("clr_req1_rsp", 64'(got1), 64'd1);
        chk("clr_req1_to", 64'(to), 64'd0);
        mon_en = 1'b0;
        chk("clr_wr_cnt", 64'(clr_wr_cnt), 64'd32);
        chk("clr_addr_err", 64'(clr_addr_err), 64'd0);
        chk("clr_data_err", 64'(clr_data_err), 64'd0);
        chk("clr_done_cnt", 64'(clr_done_cnt), 64'd1);
        chk("clr_to_cnt", 64'(clr_to_cnt), 64'd0);
        chk("clr_acc_busy", 64'(acc_busy), 64'd0);
        chk("clr_busy_end", 64'(bus.clr_busy), 64'd0);
        run_req(0, 1'b0, 5'd9, 32'd0, rd, to, lat);
        chk("clr_readback", 64'(rd), 64'd0);

        // 6. Reset mid-WAIT, late ack ignored
        ack_en = 1'b0;
        bus.rq_wr[0] = 1'b0; bus.rq_addr[4:0] = 5'd1; bus.rq_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst6_accept", 64'(bus.rq_accept), 64'd1);
        bus.rq_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst6_tbl_req", 64'({bus.tbl_rd_req, bus.tbl_wr_req}), 64'd0);
        chk("rst6_rd_addr", 64'(bus.tbl_rd_addr), 64'd0);
        chk("rst6_accept0", 64'(bus.rq_accept), 64'd0);
        rst = 1'b0;
        inj_data = 32'hDEADBEEF;
        inj_rd_ack = 1'b1;
        @(negedge clk);
        inj_rd_ack = 1'b0;
        late = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) late++;
        end
        chk("late_ack_ignored", 64'(late), 64'd0);
        ack_en = 1'b1;
        run_req(1, 1'b0, 5'd9, 32'd0, rd, to, lat);
        chk("rst6_next_to", 64'(to), 64'd0);
        chk("rst6_next_lat", 64'(lat), 64'd2);
        chk("rst6_next_data", 64'(rd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
